// File: rtl/particle_rasterizer.sv
// particle_rasterizer: double-buffered frame builder that stamps N_PART
// particles as 3x3 masks into a GRID x GRID monochrome back buffer. It paints
// one pixel per clock and copies the finished frame to the matrix output on
// each frame tick.
// Optional build macro RASTER_WRAP_EN: stamp pixels that fall off the grid
// wrap toroidally instead of being clipped.
module particle_rasterizer #(
  parameter int GRID         = 16,
  parameter int N_PART       = 4,
  parameter int FRAC         = 4,
  parameter int FRAME_CYCLES = 10000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [16*N_PART-1:0]   pos_x,
  input  logic [16*N_PART-1:0]   pos_y,
  input  logic [9*N_PART-1:0]    stamp,
  output logic [GRID*GRID-1:0]   matrix,
  output logic                   frame_valid,
  output logic                   busy
);

  localparam int LG = $clog2(GRID);
  localparam int PW = (N_PART > 1) ? $clog2(N_PART) : 1;
  localparam int CW = $clog2(FRAME_CYCLES);
  localparam logic [CW-1:0]       CNT_MAX = CW'(FRAME_CYCLES - 1);
  localparam logic [PW-1:0]       P_LAST  = PW'(N_PART - 1);
  localparam logic signed [16:0]  GRID_S  = 17'(GRID);

  typedef enum logic [1:0] {IDLE, CLEAR, PAINT, SWAP} state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q;
  logic [PW-1:0]          p_q, p_d;
  logic [3:0]             s_q, s_d;
  logic signed [15:0]     sx_q [N_PART];
  logic signed [15:0]     sy_q [N_PART];
  logic [8:0]             st_q [N_PART];
  logic [GRID*GRID-1:0]   back_q;
  logic [GRID*GRID-1:0]   matrix_q;
  logic                   fv_q;

  logic                   tick;
  logic                   snap_en, clear_en, paint_en, swap_en;
  logic signed [16:0]     cx, cy, px, py;
  logic                   in_range, hit;
  logic [2*LG-1:0]        idx;

  // Column offset of stamp bit s: bits 0,3,6 are left, 2,5,8 are right.
  function automatic logic signed [16:0] off_x(input logic [3:0] s);
    case (s)
      4'd0, 4'd3, 4'd6: return -17'sd1;
      4'd1, 4'd4, 4'd7: return 17'sd0;
      default:          return 17'sd1;
    endcase
  endfunction

  // Row offset of stamp bit s: bits 0..2 are the row above the centre.
  function automatic logic signed [16:0] off_y(input logic [3:0] s);
    if (s < 4'd3)      return -17'sd1;
    else if (s < 4'd6) return 17'sd0;
    else               return 17'sd1;
  endfunction

  assign tick = (cnt_q == '0);

  // Free-running frame counter; a tick is the cycle where it reads zero.
  always_ff @(posedge clk) begin
    if (reset)                 cnt_q <= '0;
    else if (cnt_q == CNT_MAX) cnt_q <= '0;
    else                       cnt_q <= cnt_q + 1'b1;
  end

  // Sequencer registers: state, particle index and stamp-bit index.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      p_q     <= '0;
      s_q     <= '0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      s_q     <= s_d;
    end
  end

  // Next-state logic: snapshot on a tick, clear, walk every (p,s), then swap.
  always_comb begin
    state_d  = state_q;
    p_d      = p_q;
    s_d      = s_q;
    snap_en  = 1'b0;
    clear_en = 1'b0;
    paint_en = 1'b0;
    swap_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (tick && enable) begin
          snap_en = 1'b1;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        clear_en = 1'b1;
        p_d      = '0;
        s_d      = '0;
        state_d  = PAINT;
      end
      PAINT: begin
        paint_en = 1'b1;
        if (s_q == 4'd8) begin
          s_d = '0;
          if (p_q == P_LAST) state_d = SWAP;
          else               p_d     = p_q + 1'b1;
        end else begin
          s_d = s_q + 1'b1;
        end
      end
      SWAP: begin
        swap_en = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Pixel address of the current stamp bit, kept wide and signed until the
  // range test so far-off particles can never alias onto the grid.
  always_comb begin
    cx       = {sx_q[p_q][15], sx_q[p_q]};
    cy       = {sy_q[p_q][15], sy_q[p_q]};
    px       = (cx >>> FRAC) + off_x(s_q);
    py       = (cy >>> FRAC) + off_y(s_q);
    in_range = !px[16] && (px < GRID_S) && !py[16] && (py < GRID_S);
`ifdef RASTER_WRAP_EN
    hit      = st_q[p_q][s_q];
`else
    hit      = st_q[p_q][s_q] && in_range;
`endif
    idx      = {py[LG-1:0], px[LG-1:0]};
  end

  // Input snapshot, held for the whole frame so mid-frame input changes wait.
  always_ff @(posedge clk) begin
    if (snap_en) begin
      for (int i = 0; i < N_PART; i++) begin
        sx_q[i] <= pos_x[16*i +: 16];
        sy_q[i] <= pos_y[16*i +: 16];
        st_q[i] <= stamp[9*i +: 9];
      end
    end
  end

  // Back buffer: cleared at frame start, then painted by OR-ing single pixels.
  always_ff @(posedge clk) begin
    if (reset || clear_en)  back_q      <= '0;
    else if (paint_en && hit) back_q[idx] <= 1'b1;
  end

  // Front buffer and its one-cycle update strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      matrix_q <= '0;
      fv_q     <= 1'b0;
    end else begin
      fv_q <= swap_en;
      if (swap_en) matrix_q <= back_q;
    end
  end

  assign matrix      = matrix_q;
  assign frame_valid = fv_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_particle_rasterizer.sv
// Scoreboard bench for particle_rasterizer: expected frames are queued as the
// stimulus is applied and compared when frame_valid pulses.
module tb_particle_rasterizer;

  localparam int GRID   = 16;
  localparam int N_PART = 4;
  localparam int FC     = 50;
  localparam int NPIX   = GRID * GRID;

  logic                  clk;
  logic                  reset;
  logic                  enable;
  logic [16*N_PART-1:0]  pos_x;
  logic [16*N_PART-1:0]  pos_y;
  logic [9*N_PART-1:0]   stamp;
  logic [NPIX-1:0]       matrix;
  logic                  frame_valid;
  logic                  busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int last_fv  = 0;
  bit have_last = 0;
  logic [NPIX-1:0] held;
  logic [NPIX-1:0] exp_q [$];

  particle_rasterizer #(
    .GRID(GRID), .N_PART(N_PART), .FRAC(4), .FRAME_CYCLES(FC)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .pos_x(pos_x), .pos_y(pos_y), .stamp(stamp),
    .matrix(matrix), .frame_valid(frame_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [NPIX-1:0] got,
                           input logic [NPIX-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [NPIX-1:0] bitv(input int i);
    logic [NPIX-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  task automatic set_part(input int i, input int x, input int y, input logic [8:0] st);
    pos_x[16*i +: 16] = x[15:0];
    pos_y[16*i +: 16] = y[15:0];
    stamp[9*i +: 9]   = st;
  endtask

  // Wait for one frame_valid pulse and check the frame against the scoreboard.
  task automatic wait_frame(input int bcnt0);
    int n, bcnt;
    bit stable, seen;
    logic [NPIX-1:0] e;
    n = 0; bcnt = bcnt0; stable = 1'b1; seen = 1'b0;
    while (!seen && n < 200) begin
      step();
      n++;
      if (frame_valid) seen = 1'b1;
      else begin
        if (busy) bcnt++;
        if (matrix !== held) stable = 1'b0;
      end
    end
    if (!seen) begin
      check_val("fv_timeout", 0, 1);
      return;
    end
    check_val("hold", NPIX'(stable), 1);
    if (exp_q.size() == 0) begin
      check_val("sb_empty", 0, 1);
      e = '0;
    end else begin
      e = exp_q.pop_front();
    end
    check_val("matrix", matrix, e);
    check_val("busy_len", NPIX'(bcnt), 38);
    if (have_last) check_val("period", NPIX'(cyc - last_fv), FC);
    last_fv   = cyc;
    have_last = 1'b1;
    held      = matrix;
    step();
    check_val("fv_pulse", NPIX'(frame_valid), 0);
  endtask

  task automatic wait_busy();
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!busy && n < 100);
    check_val("busy_rise", NPIX'(busy), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=hang exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    logic [NPIX-1:0] e2;
    clk = 1'b0; reset = 1'b1; enable = 1'b0;
    pos_x = '0; pos_y = '0; stamp = '0;
    held = '0;
    repeat (3) step();
    check_val("rst_matrix", matrix, '0);
    check_val("rst_fv", NPIX'(frame_valid), 0);
    check_val("rst_busy", NPIX'(busy), 0);

    // Single centre pixel; frame starts on the first edge after reset.
    set_part(0, 128, 128, 9'h010);
    exp_q.push_back(bitv(136));
    reset = 1'b0; enable = 1'b1;
    wait_frame(0);

    // Full stamp in the corner: clipped or wrapped.
    set_part(0, 0, 0, 9'h1FF);
    e2 = bitv(0) | bitv(1) | bitv(16) | bitv(17);
`ifdef RASTER_WRAP_EN
    e2 = e2 | bitv(15) | bitv(31) | bitv(240) | bitv(241) | bitv(255);
`endif
    exp_q.push_back(e2);
    wait_frame(0);

    // Far off-grid particle plus one at the last pixel.
    set_part(0, -16, -16, 9'h010);
    set_part(1, 255, 255, 9'h010);
    exp_q.push_back(bitv(255));
    wait_frame(0);

    // Overlap ORs; a move after the snapshot waits for the next tick.
    set_part(0, 64, 64, 9'h010);
    set_part(1, 64, 64, 9'h010);
    exp_q.push_back(bitv(68));
    wait_busy();
    set_part(0, 80, 64, 9'h010);
    exp_q.push_back(bitv(68) | bitv(69));
    wait_frame(1);
    wait_frame(0);

    // Disabled: no pulses and the display holds.
    enable = 1'b0;
    cnt = 0;
    repeat (120) begin
      step();
      if (frame_valid) cnt++;
    end
    check_val("no_fv", NPIX'(cnt), 0);
    check_val("hold_off", matrix, held);
    have_last = 1'b0;

    set_part(0, 0, 0, 9'h010);
    set_part(1, 0, 0, 9'h000);
    exp_q.push_back(bitv(0));
    enable = 1'b1;
    wait_frame(0);

    // Reset during PAINT abandons the frame and clears the display.
    set_part(0, 128, 128, 9'h010);
    wait_busy();
    repeat (19) step();
    reset = 1'b1;
    step();
    check_val("rst_mid_matrix", matrix, '0);
    check_val("rst_mid_busy", NPIX'(busy), 0);
    check_val("rst_mid_fv", NPIX'(frame_valid), 0);
    step();
    reset = 1'b0;
    held = '0;
    have_last = 1'b0;
    exp_q.push_back(bitv(136));
    wait_frame(0);
    exp_q.push_back(bitv(136));
    wait_frame(0);
    check_val("sb_drained", NPIX'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
